// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants, FSM encoding and special-case detection for the RV32M sequencer.
package muldiv_ctrl_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [6:0] OPC_RCC     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] value;
  } special_t;

  // Architecturally fixed results: divide by zero, signed overflow, multiply by zero.
  function automatic special_t special_case(input logic [2:0]      op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    special_t s;
    s.hit   = 1'b0;
    s.value = '0;
    if (!op[2]) begin
      if (a == '0 || b == '0) s.hit = 1'b1;
    end else if (b == '0) begin
      s.hit   = 1'b1;
      s.value = op[1] ? a : '1;
    end else if ((op == MD_DIV || op == MD_REM) &&
                 a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
      s.hit   = 1'b1;
      s.value = op[1] ? '0 : a;
    end
    return s;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Execute-stage <-> multiply/divide sequencer connection.
interface muldiv_ctrl_if;
  logic                            start;
  logic [2:0]                      funct3;
  logic [muldiv_ctrl_pkg::XLEN-1:0] op_a;
  logic [muldiv_ctrl_pkg::XLEN-1:0] op_b;
  logic                            flush;
  logic                            stall;
  logic                            busy;
  logic                            result_valid;
  logic [muldiv_ctrl_pkg::XLEN-1:0] result;

  modport master (output start, funct3, op_a, op_b, flush,
                  input  stall, busy, result_valid, result);
  modport slave  (input  start, funct3, op_a, op_b, flush,
                  output stall, busy, result_valid, result);
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring divide.
module muldiv_step
  import muldiv_ctrl_pkg::*;
(
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] m,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, m};
    hi_nxt  = sum[XLEN:1];
    lo_nxt  = {sum[0], lo[XLEN-1:1]};
    if (is_div) begin
      // Top bit of diff is the borrow: set means the divisor did not fit.
      if (!diff[XLEN]) begin
        hi_nxt = diff[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M iterative multiply/divide sequencer; MULDIV_FAST_SPECIAL_EN lets special
// cases bypass the iterations and complete the cycle after acceptance.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  muldiv_ctrl_if.slave  bus
);

  state_e          state, state_nxt;
  md_op_e          op_q;
  logic [CNT_W-1:0] cnt;
  logic            neg_q, spec_hit_q;
  logic [XLEN-1:0] spec_val_q, hi, lo, m, hi_nxt, lo_nxt, result_q;

  logic            signed_a, signed_b, sa, sb, accept, last_step;
  logic [XLEN-1:0] ua, ub, quo_fix, rem_fix, final_val;
  logic [2*XLEN-1:0] prod_fix;
  special_t        spec;

  always_comb begin
    signed_a = (bus.funct3 == MD_MULH) || (bus.funct3 == MD_MULHSU) ||
               (bus.funct3 == MD_DIV)  || (bus.funct3 == MD_REM);
    signed_b = (bus.funct3 == MD_MULH) || (bus.funct3 == MD_DIV) ||
               (bus.funct3 == MD_REM);
    sa   = signed_a & bus.op_a[XLEN-1];
    sb   = signed_b & bus.op_b[XLEN-1];
    ua   = sa ? -bus.op_a : bus.op_a;
    ub   = sb ? -bus.op_b : bus.op_b;
    spec = special_case(bus.funct3, bus.op_a, bus.op_b);
  end

  // Gated by rst_n so stall reads low while reset is held.
  assign accept    = rst_n && (state == S_IDLE) && bus.start && !bus.flush;
  assign last_step = (state == S_BUSY) && (cnt == CNT_W'(XLEN-1));

  muldiv_step u_step (
    .is_div (op_q[2]),
    .hi     (hi),
    .lo     (lo),
    .m      (m),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  always_comb begin
    prod_fix = neg_q ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
    quo_fix  = neg_q ? -lo_nxt : lo_nxt;
    rem_fix  = neg_q ? -hi_nxt : hi_nxt;
    case (op_q)
      MD_MUL:                      final_val = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_val = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             final_val = quo_fix;
      default:                     final_val = rem_fix;
    endcase
    if (spec_hit_q) final_val = spec_val_q;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) begin
`ifdef MULDIV_FAST_SPECIAL_EN
        state_nxt = spec.hit ? S_DONE : S_BUSY;
`else
        state_nxt = S_BUSY;
`endif
      end
      S_BUSY: begin
        if (bus.flush)      state_nxt = S_IDLE;
        else if (last_step) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= MD_MUL;
      cnt        <= '0;
      neg_q      <= 1'b0;
      spec_hit_q <= 1'b0;
      spec_val_q <= '0;
      hi         <= '0;
      lo         <= '0;
      m          <= '0;
      result_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q       <= md_op_e'(bus.funct3);
        neg_q      <= (bus.funct3[2] && bus.funct3[1]) ? sa : (sa ^ sb);
        spec_hit_q <= spec.hit;
        spec_val_q <= spec.value;
        cnt        <= '0;
        hi         <= '0;
        lo         <= bus.funct3[2] ? ua : ub;
        m          <= bus.funct3[2] ? ub : ua;
`ifdef MULDIV_FAST_SPECIAL_EN
        if (spec.hit) result_q <= spec.value;
`endif
      end else if (state == S_BUSY && !bus.flush) begin
        hi  <= hi_nxt;
        lo  <= lo_nxt;
        cnt <= cnt + 1'b1;
        if (last_step) result_q <= final_val;
      end
    end
  end

  assign bus.stall        = accept || (state == S_BUSY);
  assign bus.busy         = (state != S_IDLE);
  assign bus.result_valid = (state == S_DONE) && !bus.flush;
  assign bus.result       = result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl (latency, arithmetic, flush, reset).
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int FULL_LAT = 33;
`ifdef MULDIV_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = FULL_LAT;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  muldiv_ctrl_if bus ();

  muldiv_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Holds start until result_valid (instruction stays in execute while stalled).
  // lat counts cycles after the start cycle; -1 means no result within budget.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int stalls);
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f3; bus.op_a = a; bus.op_b = b;
    res = '0; lat = -1; stalls = 0;
    #1;
    if (bus.stall) stalls++;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.stall) stalls++;
      if (bus.result_valid) begin
        res = bus.result;
        lat = i;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.stall, bus.busy, bus.result_valid} !== 3'b000 || bus.result !== 32'h0) begin
      errors++;
      $display("FAIL reset: stall/busy/valid=%b result=%h expected 000 / 00000000",
               {bus.stall, bus.busy, bus.result_valid}, bus.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul_latency();
    logic [31:0] res;
    int lat, stalls;
    do_op(MD_MUL, 32'd7, 32'hFFFF_FFFD, res, lat, stalls);
    checks++;
    if (res !== 32'hFFFF_FFEB) begin
      errors++; $display("FAIL mul_result: got=%h expected=FFFFFFEB", res);
    end
    checks++;
    if (lat !== FULL_LAT) begin
      errors++; $display("FAIL mul_latency: got=%0d expected=%0d", lat, FULL_LAT);
    end
    checks++;
    if (stalls !== FULL_LAT) begin
      errors++; $display("FAIL mul_stall_cycles: got=%0d expected=%0d", stalls, FULL_LAT);
    end
    @(negedge clk);
    checks++;
    if ({bus.result_valid, bus.busy, bus.stall} !== 3'b000 || bus.result !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mul_after_done: valid/busy/stall=%b result=%h expected 000 / FFFFFFEB",
               {bus.result_valid, bus.busy, bus.stall}, bus.result);
    end
  endtask

  task automatic test_mul_variants();
    logic [2:0]  f3  [5] = '{MD_MULH, MD_MULHU, MD_MULHSU, MD_MUL, MD_MULHU};
    logic [31:0] a   [5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0};
    logic [31:0] b   [5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hDEAD_BEEF};
    logic [31:0] exp [5] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h0};
    int          el  [5] = '{FULL_LAT, FULL_LAT, FULL_LAT, SPEC_LAT, SPEC_LAT};
    logic [31:0] res;
    int lat, stalls;
    for (int i = 0; i < 5; i++) begin
      do_op(f3[i], a[i], b[i], res, lat, stalls);
      checks++;
      if (res !== exp[i] || lat !== el[i]) begin
        errors++;
        $display("FAIL mul_variant[%0d]: result=%h lat=%0d expected %h lat=%0d",
                 i, res, lat, exp[i], el[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3  [5] = '{MD_DIV, MD_REM, MD_DIVU, MD_REMU, MD_REMU};
    logic [31:0] a   [5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'hFFFF_FFFF};
    logic [31:0] b   [5] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd16};
    logic [31:0] exp [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hF};
    logic [31:0] res;
    int lat, stalls;
    for (int i = 0; i < 5; i++) begin
      do_op(f3[i], a[i], b[i], res, lat, stalls);
      checks++;
      if (res !== exp[i] || lat !== FULL_LAT) begin
        errors++;
        $display("FAIL div[%0d]: result=%h lat=%0d expected %h lat=%0d",
                 i, res, lat, exp[i], FULL_LAT);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3  [6] = '{MD_DIVU, MD_REM, MD_DIV, MD_REM, MD_DIV, MD_REMU};
    logic [31:0] a   [6] = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FF00, 32'hFFFF_FF00};
    logic [31:0] b   [6] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
    logic [31:0] exp [6] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FF00};
    logic [31:0] res;
    int lat, stalls;
    for (int i = 0; i < 6; i++) begin
      do_op(f3[i], a[i], b[i], res, lat, stalls);
      checks++;
      if (res !== exp[i] || lat !== SPEC_LAT || stalls !== SPEC_LAT) begin
        errors++;
        $display("FAIL special[%0d]: result=%h lat=%0d stalls=%0d expected %h lat=%0d",
                 i, res, lat, stalls, exp[i], SPEC_LAT);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, res;
    int lat, stalls;
    logic seen_valid;
    logic done_found;

    // Flush alongside start in IDLE: not accepted.
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = MD_DIVU; bus.op_a = 32'd50; bus.op_b = 32'd5;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("FAIL flush_idle_stall: got=%b expected=0", bus.stall);
    end
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle_busy: got=%b expected=0", bus.busy);
    end

    // Flush mid-BUSY at N+10.
    prev = bus.result;
    seen_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = MD_DIV; bus.op_a = 32'd1000; bus.op_b = 32'd3;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.result_valid) seen_valid = 1'b1;
    end
    bus.flush = 1'b1;
    #1;
    if (bus.result_valid) seen_valid = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.start = 1'b0;
    #1;
    checks++;
    if ({bus.stall, bus.busy, bus.result_valid, seen_valid} !== 4'b0000 || bus.result !== prev) begin
      errors++;
      $display("FAIL flush_busy: stall/busy/valid/seen=%b result=%h expected 0000 / %h",
               {bus.stall, bus.busy, bus.result_valid, seen_valid}, bus.result, prev);
    end
    do_op(MD_MUL, 32'd11, 32'd13, res, lat, stalls);
    checks++;
    if (res !== 32'd143 || lat !== FULL_LAT) begin
      errors++;
      $display("FAIL flush_restart: result=%h lat=%0d expected %h lat=%0d",
               res, lat, 32'd143, FULL_LAT);
    end

    // Flush during DONE: result registered but valid suppressed.
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = MD_MUL; bus.op_a = 32'd3; bus.op_b = 32'd5;
    done_found = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.busy && !bus.stall) begin
        done_found = 1'b1;
        break;
      end
    end
    bus.flush = 1'b1;
    #1;
    checks++;
    if (!done_found || bus.result_valid !== 1'b0 || bus.result !== 32'd15) begin
      errors++;
      $display("FAIL flush_done: found=%b valid=%b result=%h expected 1 / 0 / 0000000f",
               done_found, bus.result_valid, bus.result);
    end
    @(negedge clk);
    bus.flush = 1'b0; bus.start = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    int lat, stalls;
    int valid_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = MD_MUL; bus.op_a = 32'd7; bus.op_b = 32'd9;
    for (int i = 1; i <= 5; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.stall, bus.busy, bus.result_valid} !== 3'b000 || bus.result !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: stall/busy/valid=%b result=%h expected 000 / 00000000",
               {bus.stall, bus.busy, bus.result_valid}, bus.result);
    end
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    valid_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.result_valid || bus.busy) valid_cnt++;
    end
    checks++;
    if (valid_cnt !== 0) begin
      errors++; $display("FAIL reset_no_result: active cycles=%0d expected=0", valid_cnt);
    end
    do_op(MD_DIVU, 32'd100, 32'd7, res, lat, stalls);
    checks++;
    if (res !== 32'd14 || lat !== FULL_LAT) begin
      errors++;
      $display("FAIL reset_restart: result=%h lat=%0d expected 0000000e lat=%0d", res, lat, FULL_LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3  [3] = '{MD_MUL, MD_DIV, MD_REM};
    logic [31:0] a   [3] = '{32'd6, 32'hFFFF_FF9C, 32'hFFFF_FF9C};
    logic [31:0] b   [3] = '{32'd7, 32'd7, 32'd7};
    logic [31:0] exp [3] = '{32'd42, 32'hFFFF_FFF2, 32'hFFFF_FFFE};
    logic [31:0] res;
    int lat, stalls;
    // do_op returns in the DONE cycle, so each next start lands right after DONE.
    for (int i = 0; i < 3; i++) begin
      do_op(f3[i], a[i], b[i], res, lat, stalls);
      checks++;
      if (res !== exp[i] || lat !== FULL_LAT) begin
        errors++;
        $display("FAIL back_to_back[%0d]: result=%h lat=%0d expected %h lat=%0d",
                 i, res, lat, exp[i], FULL_LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_latency();
    test_mul_variants();
    test_div();
    test_special();
    test_flush();
    test_async_reset();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
